// File: rtl/pipelined_addsub_pkg.sv
// Shared ALU datapath definitions: opcode encodings, default width and flag helpers.
package pipelined_addsub_pkg;

    localparam int   ALU_WIDTH  = 32;
    localparam logic ALU_OP_ADD = 1'b0;
    localparam logic ALU_OP_SUB = 1'b1;

    // Two's-complement overflow from the carries around the top bit.
    function automatic logic signed_ovf(input logic c_into_msb, input logic c_out_msb);
        return c_into_msb ^ c_out_msb;
    endfunction

endpackage

// File: rtl/pipelined_addsub_segment.sv
// One carry-chain segment: a SEG-bit ripple adder built from full_adder cells.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module addsub_segment #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] sum,
    output logic           cout,
    output logic           c_msb
);
    // Each bit keeps its own carry nets so the ripple is not one self-referencing vector.
    for (genvar g = 0; g < SEG; g++) begin : g_bit
        logic ci;
        logic co;
        if (g == 0) begin : g_first
            assign ci = cin;
        end else begin : g_chain
            assign ci = g_bit[g-1].co;
        end
        full_adder u_fa (
            .a    (a[g]),
            .b    (b[g]),
            .cin  (ci),
            .s    (sum[g]),
            .cout (co)
        );
    end

    assign cout  = g_bit[SEG-1].co;
    assign c_msb = g_bit[SEG-1].ci;

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract: carry chain split into STAGES registered segments with
// valid/ready flow control. WIDTH must be a multiple of STAGES.
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int STAGES = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src1,
    input  logic [WIDTH-1:0] src2,
    input  logic             sub_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow,
    output logic             zero
);
    localparam int SEG = WIDTH / STAGES;

    logic [STAGES-1:0] vld_q, vld_d, ld;
    logic [STAGES:0]   adv, up_vld;

    // Per stage: acc holds finished low sum bits plus untouched high A bits; b holds B'.
    logic [WIDTH-1:0]  acc_q [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [STAGES-1:0] c_q;

    logic [WIDTH-1:0]  a_in  [STAGES];
    logic [WIDTH-1:0]  b_in  [STAGES];
    logic [WIDTH-1:0]  acc_d [STAGES];
    logic [STAGES-1:0] c_in;
    logic [SEG-1:0]    seg_sum [STAGES];
    logic [STAGES-1:0] seg_cout, seg_cmsb;

    logic [WIDTH-1:0]  sum_q;
    logic              cout_q, ovf_q, zero_q;

    assign up_vld = {vld_q, in_valid};

    // A slot advances when it is empty or its downstream neighbour advances.
    always_comb begin
        adv         = '0;
        vld_d       = vld_q;
        ld          = '0;
        adv[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = ~vld_q[k] | adv[k+1];
        end
        for (int k = 0; k < STAGES; k++) begin
            if (adv[k]) begin
                vld_d[k] = up_vld[k];
            end
            ld[k] = adv[k] & up_vld[k];
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = vld_q[STAGES-1];

    always_comb begin
        a_in[0] = src1;
        b_in[0] = (sub_i == ALU_OP_ADD) ? src2 : ~src2;
        c_in    = '0;
        c_in[0] = (sub_i == ALU_OP_SUB);
        for (int k = 1; k < STAGES; k++) begin
            a_in[k] = acc_q[k-1];
            b_in[k] = b_q[k-1];
            c_in[k] = c_q[k-1];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_seg
        addsub_segment #(.SEG(SEG)) u_seg (
            .a     (a_in[g][g*SEG +: SEG]),
            .b     (b_in[g][g*SEG +: SEG]),
            .cin   (c_in[g]),
            .sum   (seg_sum[g]),
            .cout  (seg_cout[g]),
            .c_msb (seg_cmsb[g])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            acc_d[k]                = a_in[k];
            acc_d[k][k*SEG +: SEG]  = seg_sum[k];
        end
    end

    // ---- stage valid bits ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    // ---- stage datapath registers ----
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < STAGES; k++) begin
            if (ld[k]) begin
                acc_q[k] <= acc_d[k];
                b_q[k]   <= b_in[k];
                c_q[k]   <= seg_cout[k];
            end
        end
    end

    // ---- output stage ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (ld[STAGES-1]) begin
            sum_q  <= acc_d[STAGES-1];
            cout_q <= seg_cout[STAGES-1];
            ovf_q  <= signed_ovf(seg_cmsb[STAGES-1], seg_cout[STAGES-1]);
            zero_q <= ~|acc_d[STAGES-1];
        end
    end

    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
    assign zero     = zero_q;

    // Last-stage intermediates and inner-segment carries have no consumer.
    logic unused_ok;
    always_comb begin
        unused_ok = ^{acc_q[STAGES-1], b_q[STAGES-1], c_q[STAGES-1], seg_cmsb, up_vld[STAGES]};
    end

endmodule

// File: tb/tb_pipelined_addsub.sv
// Bench for pipelined_addsub: directed vectors, stall/reset sequences and random
// streams against an arithmetic reference, plus three extra parameterisations.
module tb_pipelined_addsub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_i, in_valid, in_ready, sub_i, out_valid, out_ready;
    logic        cout, overflow, zero;
    logic [31:0] src1, src2, sum;

    pipelined_addsub #(.WIDTH(32), .STAGES(4)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .src1      (src1),
        .src2      (src2),
        .sub_i     (sub_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .overflow  (overflow),
        .zero      (zero)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    endtask

    // Reference: {cout,sum} = A + B' + sub; overflow from operand/result signs.
    function automatic logic [34:0] model32(input logic [31:0] a, input logic [31:0] b, input logic s);
        logic [31:0] bp;
        logic [32:0] f;
        bp = s ? ~b : b;
        f  = {1'b0, a} + {1'b0, bp} + {32'b0, s};
        return {f[32], (a[31] == bp[31]) && (f[31] != a[31]), f[31:0] == 32'h0, f[31:0]};
    endfunction

    logic [34:0] q[$];
    logic        last_acc, last_pop;

    task automatic step(input logic rdy, input logic offer, input logic [31:0] a,
                        input logic [31:0] b, input logic s);
        @(negedge clk);
        out_ready = rdy;
        in_valid  = offer;
        src1      = a;
        src2      = b;
        sub_i     = s;
        #1;
        last_acc = in_valid && in_ready;
        last_pop = out_valid && out_ready;
        if (last_pop) begin
            if (q.size() == 0) chk("unexpected_result", 128'(out_valid), 128'(0));
            else chk("stream_result", 128'({cout, overflow, zero, sum}), 128'(q.pop_front()));
        end
        if (last_acc) q.push_back(model32(a, b, s));
    endtask

    task automatic run_single(input logic [31:0] a, input logic [31:0] b, input logic s, output int lat);
        step(1'b1, 1'b1, a, b, s);
        if (!last_acc) chk("single_accept", 128'(last_acc), 128'(1));
        lat = 0;
        while (!out_valid && lat < 12) begin
            step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
            lat++;
        end
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [31:0] e_sum;
        logic        e_cout;
        logic        e_ovf;
        logic        e_zero;
    } vec_t;

    vec_t        vt[7];
    logic [31:0] ba[8], bb[8];
    logic        bs[8];

    initial begin
        int lat;
        int idx;
        rst_i = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        src1 = '0; src2 = '0; sub_i = 1'b0;

        vt[0] = '{32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0008, 1'b0, 1'b0, 1'b0};
        vt[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vt[2] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
        vt[3] = '{32'h0000_0005, 32'h0000_0007, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
        vt[4] = '{32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
        vt[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
        vt[6] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 32'h0100_0000, 1'b0, 1'b0, 1'b0};

        repeat (2) @(negedge clk);
        chk("reset_out_valid", 128'(out_valid), 128'(0));
        chk("reset_fields", 128'({cout, overflow, zero, sum}), 128'(0));
        rst_i = 1'b0;
        step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("in_ready_after_reset", 128'(in_ready), 128'(1));

        for (int i = 0; i < 7; i++) begin
            run_single(vt[i].a, vt[i].b, vt[i].s, lat);
            chk($sformatf("vec%0d_latency", i), 128'(lat), 128'(4));
            chk($sformatf("vec%0d_result", i), 128'({cout, overflow, zero, sum}),
                128'({vt[i].e_cout, vt[i].e_ovf, vt[i].e_zero, vt[i].e_sum}));
        end

        // Back-pressure: 6 stalled cycles, then release.
        for (int i = 0; i < 8; i++) begin
            ba[i] = $urandom; bb[i] = $urandom; bs[i] = 1'($urandom_range(0, 1));
        end
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            step(1'b0, idx < 8, ba[idx % 8], bb[idx % 8], bs[idx % 8]);
            chk($sformatf("bp_in_ready_c%0d", c), 128'(in_ready), 128'(c < 4));
            if (last_acc) idx++;
            if (c >= 4) begin
                chk($sformatf("bp_out_valid_c%0d", c), 128'(out_valid), 128'(1));
                if (q.size() > 0) chk($sformatf("bp_stall_hold_c%0d", c),
                                      128'({cout, overflow, zero, sum}), 128'(q[0]));
            end
        end
        chk("bp_accepted_before_full", 128'(idx), 128'(4));
        for (int c = 0; c < 8; c++) begin
            step(1'b1, idx < 8, ba[idx % 8], bb[idx % 8], bs[idx % 8]);
            chk($sformatf("bp_drain_valid_c%0d", c), 128'(out_valid), 128'(1));
            if (last_acc) idx++;
        end
        chk("bp_all_accepted", 128'(idx), 128'(8));
        chk("bp_all_delivered", 128'(q.size()), 128'(0));

        // Reset with three ops in flight, oldest already at the output.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, $urandom, $urandom, 1'($urandom_range(0, 1)));
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("rst_pre_out_valid", 128'(out_valid), 128'(1));
        #2 rst_i = 1'b1;
        #1;
        chk("rst_async_out_valid", 128'(out_valid), 128'(0));
        chk("rst_async_fields", 128'({cout, overflow, zero, sum}), 128'(0));
        q.delete();
        @(negedge clk);
        rst_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
            chk($sformatf("rst_no_stale_%0d", i), 128'(out_valid), 128'(0));
        end
        run_single(32'h1234_5678, 32'h1111_1111, 1'b0, lat);
        chk("rst_next_latency", 128'(lat), 128'(4));
        chk("rst_next_result", 128'({cout, overflow, zero, sum}), 128'({3'b000, 32'h2345_6789}));

        // Random stream with random back-pressure.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, $urandom,
                 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 20 && q.size() > 0; i++) step(1'b1, 1'b0, 32'h0, 32'h0, 1'b0);
        chk("random_drain", 128'(q.size()), 128'(0));

        for (int i = 0; i < 40000 && !(sw[0].done && sw[1].done && sw[2].done); i++) @(negedge clk);
        chk("sweeps_finished", 128'({sw[0].done, sw[1].done, sw[2].done}), 128'(3'b111));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Parameter sweep: 8/1, 8/8, 64/2, each with its own reset and scoreboard.
    for (genvar g = 0; g < 3; g++) begin : sw
        localparam int W = (g == 2) ? 64 : 8;
        localparam int S = (g == 0) ? 1 : (g == 1) ? 8 : 2;

        logic         rs, iv, ir, sb, ov, orr, co, of, zr;
        logic [W-1:0] a, b, sm;
        logic [W+2:0] sq[$];
        logic         done;

        pipelined_addsub #(.WIDTH(W), .STAGES(S)) u_dut (
            .clk_i     (clk),
            .rst_i     (rs),
            .in_valid  (iv),
            .in_ready  (ir),
            .src1      (a),
            .src2      (b),
            .sub_i     (sb),
            .out_valid (ov),
            .out_ready (orr),
            .sum       (sm),
            .cout      (co),
            .overflow  (of),
            .zero      (zr)
        );

        function automatic logic [W+2:0] mdl(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
            logic [W-1:0] yp;
            logic [W:0]   f;
            yp = s ? ~y : y;
            f  = {1'b0, x} + {1'b0, yp} + {{W{1'b0}}, s};
            return {f[W], (x[W-1] == yp[W-1]) && (f[W-1] != x[W-1]), f[W-1:0] == '0, f[W-1:0]};
        endfunction

        initial begin
            int sent;
            int got;
            logic [63:0] r;
            done = 1'b0; rs = 1'b1; iv = 1'b0; orr = 1'b0; sb = 1'b0;
            a = '0; b = '0; sent = 0; got = 0;
            repeat (3) @(negedge clk);
            rs = 1'b0;
            for (int cyc = 0; cyc < 20000 && got < 1000; cyc++) begin
                @(negedge clk);
                orr = 1'($urandom_range(0, 1));
                iv  = (sent < 1000) && ($urandom_range(0, 3) != 0);
                r   = {$urandom, $urandom};
                a   = r[W-1:0];
                r   = {$urandom, $urandom};
                b   = r[W-1:0];
                sb  = 1'($urandom_range(0, 1));
                #1;
                if (ov && orr) begin
                    if (sq.size() == 0) chk($sformatf("sweep%0d_extra_result", g), 128'(ov), 128'(0));
                    else chk($sformatf("sweep%0d_W%0d_S%0d", g, W, S), 128'({co, of, zr, sm}),
                             128'(sq.pop_front()));
                    got++;
                end
                if (iv && ir) begin
                    sq.push_back(mdl(a, b, sb));
                    sent++;
                end
            end
            chk($sformatf("sweep%0d_result_count", g), 128'(got), 128'(1000));
            done = 1'b1;
        end
    end

endmodule
